// File: rtl/sprite_anim_renderer.sv
// sprite_anim_renderer
// Places one multi-frame palettised sprite at a programmable screen position.
// Two-stage pipeline: stage 1 registers the sprite ROM address, stage 2 registers the RGB.
// Optional feature macro: SPRITE_FLIP_EN (honour flip_h for horizontal mirroring).
//
// Ports:
//   vga_clk, reset_n              pixel clock, async active-low reset
//   DrawX, DrawY, blank           current pixel and visible-region flag
//   frame_tick                    one pulse per video frame
//   pos_x, pos_y                  requested sprite top-left (latched on frame_tick)
//   anim_en, anim_restart         animation advance enable / return to frame 0
//   flip_h                        horizontal mirror (SPRITE_FLIP_EN only)
//   bg_red/green/blue             background colour
//   rom_address / rom_q           sprite ROM address out / palette index in
//   palette_index                 pass-through of rom_q to the palette
//   palette_red/green/blue        palette colour for palette_index
//   red, green, blue, sprite_hit  registered pixel output
module sprite_anim_renderer #(
    parameter int unsigned SPR_W       = 50,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned ADDR_W      = 14
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_tick,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              anim_en,
    input  logic              anim_restart,
    input  logic              flip_h,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  palette_index,
    input  logic [3:0]        palette_red,
    input  logic [3:0]        palette_green,
    input  logic [3:0]        palette_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    localparam int unsigned FRAME_CW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int unsigned TICK_CW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned FRAME_SZ = SPR_W * SPR_H;

    logic [9:0]          r_cur_x;
    logic [9:0]          r_cur_y;
    logic [FRAME_CW-1:0] r_frame;
    logic [TICK_CW-1:0]  r_tick_cnt;
    logic [ADDR_W-1:0]   r_rom_address;
    logic                r_hit_d;
    logic                r_blank_d;
    logic [3:0]          r_red;
    logic [3:0]          r_green;
    logic [3:0]          r_blue;
    logic                r_sprite_hit;

    logic [10:0]         w_x_lo;
    logic [10:0]         w_x_hi;
    logic [10:0]         w_y_lo;
    logic [10:0]         w_y_hi;
    logic                w_hit;
    logic [9:0]          w_lx_raw;
    logic [9:0]          w_lx;
    logic [9:0]          w_ly;
    logic [ADDR_W-1:0]   w_addr;

    // Hit window in 11 bits so a sprite near the right/bottom edge clips instead of wrapping
    assign w_x_lo = {1'b0, r_cur_x};
    assign w_x_hi = w_x_lo + 11'(SPR_W);
    assign w_y_lo = {1'b0, r_cur_y};
    assign w_y_hi = w_y_lo + 11'(SPR_H);
    assign w_hit  = ({1'b0, DrawX} >= w_x_lo) && ({1'b0, DrawX} < w_x_hi) &&
                    ({1'b0, DrawY} >= w_y_lo) && ({1'b0, DrawY} < w_y_hi);

    assign w_lx_raw = DrawX - r_cur_x;
    assign w_ly     = DrawY - r_cur_y;

`ifdef SPRITE_FLIP_EN
    assign w_lx = flip_h ? (10'(SPR_W - 1) - w_lx_raw) : w_lx_raw;
`else
    logic w_unused_flip;
    assign w_unused_flip = flip_h;
    assign w_lx          = w_lx_raw;
`endif

    // Frames are stored back-to-back, each row-major
    assign w_addr = ADDR_W'(r_frame) * ADDR_W'(FRAME_SZ)
                  + ADDR_W'(w_ly) * ADDR_W'(SPR_W)
                  + ADDR_W'(w_lx);

    // Position latch and animation timebase; restart overrides a same-tick advance
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_frame    <= '0;
            r_tick_cnt <= '0;
        end else begin
            if (frame_tick) begin
                r_cur_x <= pos_x;
                r_cur_y <= pos_y;
            end
            if (anim_restart) begin
                r_frame    <= '0;
                r_tick_cnt <= '0;
            end else if (frame_tick && anim_en) begin
                if (r_tick_cnt == TICK_CW'(FRAME_TICKS - 1)) begin
                    r_tick_cnt <= '0;
                    r_frame    <= (r_frame == FRAME_CW'(NUM_FRAMES - 1)) ? '0 : r_frame + 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1: ROM address and qualifiers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_address <= '0;
            r_hit_d       <= 1'b0;
            r_blank_d     <= 1'b0;
        end else begin
            r_rom_address <= w_hit ? w_addr : '0;
            r_hit_d       <= w_hit;
            r_blank_d     <= blank;
        end
    end

    // Stage 2: colour select; index 0 is transparent
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_sprite_hit <= 1'b0;
        end else if (!r_blank_d) begin
            r_red        <= '0;
            r_green      <= '0;
            r_blue       <= '0;
            r_sprite_hit <= 1'b0;
        end else if (r_hit_d && (rom_q != '0)) begin
            r_red        <= palette_red;
            r_green      <= palette_green;
            r_blue       <= palette_blue;
            r_sprite_hit <= 1'b1;
        end else begin
            r_red        <= bg_red;
            r_green      <= bg_green;
            r_blue       <= bg_blue;
            r_sprite_hit <= 1'b0;
        end
    end

    assign rom_address   = r_rom_address;
    assign palette_index = rom_q;
    assign red           = r_red;
    assign green         = r_green;
    assign blue          = r_blue;
    assign sprite_hit    = r_sprite_hit;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed self-checking bench for sprite_anim_renderer (default parameters).
module tb_sprite_anim_renderer;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, pos_x, pos_y;
    logic        blank, frame_tick, anim_en, anim_restart, flip_h;
    logic [3:0]  bg_red, bg_green, bg_blue;
    logic [13:0] rom_address;
    logic [2:0]  rom_q, palette_index;
    logic [3:0]  palette_red, palette_green, palette_blue;
    logic [3:0]  red, green, blue;
    logic        sprite_hit;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [13:0] obs_addr;
    logic [11:0] obs_rgb;
    logic        obs_hit;

    localparam logic [11:0] BG_RGB  = 12'h39C;
    localparam logic [11:0] PAL5    = 12'h678;

    always #5 vga_clk = ~vga_clk;

    // Palette model: colour channels offset from the index
    assign palette_red   = 4'(palette_index) + 4'd1;
    assign palette_green = 4'(palette_index) + 4'd2;
    assign palette_blue  = 4'(palette_index) + 4'd3;

    sprite_anim_renderer dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y),
        .anim_en(anim_en), .anim_restart(anim_restart), .flip_h(flip_h),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_address(rom_address), .rom_q(rom_q), .palette_index(palette_index),
        .palette_red(palette_red), .palette_green(palette_green), .palette_blue(palette_blue),
        .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit)
    );

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    // Present one pixel, capture address at n+1 and colour at n+2
    task automatic run_pixel(input logic [9:0] x, input logic [9:0] y, input logic bl);
        DrawX = x; DrawY = y; blank = bl;
        step();
        obs_addr = rom_address;
        step();
        obs_rgb = {red, green, blue};
        obs_hit = sprite_hit;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic latch(input logic [9:0] x, input logic [9:0] y);
        pos_x = x; pos_y = y;
        ticks(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; blank = 1'b1; DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) step();
        n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
        n_cmp++; if (rom_address !== 14'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rom_address); end
        n_cmp++; if (sprite_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", sprite_hit); end
        reset_n = 1'b1;
        step();
        latch(10'd0, 10'd0);
        DrawX = 10'd3; DrawY = 10'd1;
        step();
        n_cmp++; if (rom_address !== 14'd53) begin n_err++; $display("FAIL reset_first_addr53: got %0d want 53", rom_address); end
        run_pixel(10'd0, 10'd0, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL reset_first_addr0: got %0d want 0", obs_addr); end
        n_cmp++; if (obs_hit !== 1'b1) begin n_err++; $display("FAIL reset_first_hit: got %b want 1", obs_hit); end
    endtask

    task automatic test_placement();
        latch(10'd100, 10'd200);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL place_tl_addr: got %0d want 0", obs_addr); end
        run_pixel(10'd149, 10'd263, 1'b1);
        n_cmp++; if (obs_addr !== 14'd3199) begin n_err++; $display("FAIL place_br_addr: got %0d want 3199", obs_addr); end
        n_cmp++; if (obs_rgb !== PAL5 || obs_hit !== 1'b1) begin n_err++; $display("FAIL place_br_rgb: got %h/%b want %h/1", obs_rgb, obs_hit, PAL5); end
        run_pixel(10'd150, 10'd263, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL place_right_miss_addr: got %0d want 0", obs_addr); end
        n_cmp++; if (obs_rgb !== BG_RGB || obs_hit !== 1'b0) begin n_err++; $display("FAIL place_right_miss_rgb: got %h/%b want %h/0", obs_rgb, obs_hit, BG_RGB); end
        run_pixel(10'd99, 10'd200, 1'b1);
        n_cmp++; if (obs_hit !== 1'b0) begin n_err++; $display("FAIL place_left_miss: got %b want 0", obs_hit); end
        run_pixel(10'd100, 10'd264, 1'b1);
        n_cmp++; if (obs_hit !== 1'b0) begin n_err++; $display("FAIL place_bottom_miss: got %b want 0", obs_hit); end
        run_pixel(10'd125, 10'd210, 1'b1);
        n_cmp++; if (obs_addr !== 14'd525) begin n_err++; $display("FAIL place_mid_addr: got %0d want 525", obs_addr); end
    endtask

    task automatic test_transparency();
        rom_q = 3'd0;
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_rgb !== BG_RGB || obs_hit !== 1'b0) begin n_err++; $display("FAIL transp_idx0: got %h/%b want %h/0", obs_rgb, obs_hit, BG_RGB); end
        rom_q = 3'd5;
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_rgb !== PAL5 || obs_hit !== 1'b1) begin n_err++; $display("FAIL transp_idx5: got %h/%b want %h/1", obs_rgb, obs_hit, PAL5); end
        run_pixel(10'd100, 10'd200, 1'b0);
        n_cmp++; if (obs_rgb !== 12'h000 || obs_hit !== 1'b0) begin n_err++; $display("FAIL transp_blank: got %h/%b want 000/0", obs_rgb, obs_hit); end
    endtask

    task automatic test_back_to_back();
        blank = 1'b1; DrawY = 10'd201;
        for (int i = 0; i < 4; i++) begin
            DrawX = 10'(100 + i);
            step();
            n_cmp++; if (rom_address !== 14'(50 + i)) begin n_err++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, rom_address, 50 + i); end
        end
    endtask

    task automatic test_animation();
        anim_en = 1'b1;
        ticks(7);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL anim_7ticks: got %0d want 0", obs_addr); end
        ticks(1);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd3200) begin n_err++; $display("FAIL anim_frame1: got %0d want 3200", obs_addr); end
        ticks(8);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd6400) begin n_err++; $display("FAIL anim_frame2: got %0d want 6400", obs_addr); end
        ticks(8);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd9600) begin n_err++; $display("FAIL anim_frame3: got %0d want 9600", obs_addr); end
        ticks(8);
        run_pixel(10'd100, 10'd200, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL anim_wrap: got %0d want 0", obs_addr); end
        // restart coincident with the advancing tick, also moving the sprite
        ticks(7);
        pos_x = 10'd10; pos_y = 10'd20; anim_restart = 1'b1;
        ticks(1);
        anim_restart = 1'b0;
        run_pixel(10'd10, 10'd20, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0 || obs_hit !== 1'b1) begin n_err++; $display("FAIL anim_restart_tick: got %0d/%b want 0/1", obs_addr, obs_hit); end
        ticks(7);
        run_pixel(10'd10, 10'd20, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL anim_restart_cnt: got %0d want 0", obs_addr); end
        ticks(1);
        run_pixel(10'd10, 10'd20, 1'b1);
        n_cmp++; if (obs_addr !== 14'd3200) begin n_err++; $display("FAIL anim_after_restart: got %0d want 3200", obs_addr); end
        anim_en = 1'b0;
        ticks(8);
        run_pixel(10'd10, 10'd20, 1'b1);
        n_cmp++; if (obs_addr !== 14'd3200) begin n_err++; $display("FAIL anim_hold: got %0d want 3200", obs_addr); end
        anim_restart = 1'b1;
        step();
        anim_restart = 1'b0;
        run_pixel(10'd10, 10'd20, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0) begin n_err++; $display("FAIL anim_restart_pulse: got %0d want 0", obs_addr); end
    endtask

    task automatic test_flip();
        logic [13:0] exp_addr;
`ifdef SPRITE_FLIP_EN
        exp_addr = 14'd49;
`else
        exp_addr = 14'd0;
`endif
        latch(10'd0, 10'd0);
        flip_h = 1'b1;
        run_pixel(10'd0, 10'd0, 1'b1);
        flip_h = 1'b0;
        n_cmp++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL flip_addr: got %0d want %0d", obs_addr, exp_addr); end
    endtask

    task automatic test_edge_clip();
        latch(10'd620, 10'd470);
        run_pixel(10'd639, 10'd479, 1'b1);
        n_cmp++; if (obs_addr !== 14'd469 || obs_hit !== 1'b1) begin n_err++; $display("FAIL clip_addr: got %0d/%b want 469/1", obs_addr, obs_hit); end
        pos_x = 10'd0; pos_y = 10'd0;
        run_pixel(10'd639, 10'd479, 1'b1);
        n_cmp++; if (obs_addr !== 14'd469) begin n_err++; $display("FAIL clip_midframe: got %0d want 469", obs_addr); end
        ticks(1);
        run_pixel(10'd639, 10'd479, 1'b1);
        n_cmp++; if (obs_addr !== 14'd0 || obs_hit !== 1'b0) begin n_err++; $display("FAIL clip_moved: got %0d/%b want 0/0", obs_addr, obs_hit); end
    endtask

    task automatic test_reset_midline();
        latch(10'd100, 10'd200);
        run_pixel(10'd101, 10'd200, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({red, green, blue} !== 12'h000 || sprite_hit !== 1'b0 || rom_address !== 14'd0) begin
            n_err++; $display("FAIL midline_reset: got %h/%b/%0d want 000/0/0", {red, green, blue}, sprite_hit, rom_address);
        end
        step();
        reset_n = 1'b1;
        DrawX = 10'd1; DrawY = 10'd0; blank = 1'b1;
        step();
        n_cmp++; if (rom_address !== 14'd1) begin n_err++; $display("FAIL release_addr: got %0d want 1", rom_address); end
        step();
        n_cmp++; if ({red, green, blue} !== PAL5 || sprite_hit !== 1'b1) begin n_err++; $display("FAIL release_rgb: got %h/%b want %h/1", {red, green, blue}, sprite_hit, PAL5); end
    endtask

    initial begin
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b1; frame_tick = 1'b0;
        pos_x = '0; pos_y = '0; anim_en = 1'b0; anim_restart = 1'b0; flip_h = 1'b0;
        bg_red = 4'h3; bg_green = 4'h9; bg_blue = 4'hC; rom_q = 3'd5;
        test_reset();
        test_placement();
        test_transparency();
        test_back_to_back();
        test_animation();
        test_flip();
        test_edge_clip();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_anim_renderer.md
# sprite_anim_renderer

Parametrised animated-sprite renderer for the VGA pipeline: places one multi-frame, palettised sprite at a programmable screen position instead of stretching a single image across the display. It computes the sprite ROM address from DrawX/DrawY and the position latched at the frame boundary. It steps through animation frames on a frame-tick timebase, treats palette index 0 as transparent over a background colour, and drives registered RGB to the VGA output. It sits between the VGA controller, an external synchronous sprite ROM, and an external combinational palette.

## Interface
- SPR_W, 50, sprite width in pixels
- SPR_H, 64, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- IDX_W, 3, palette index width
- FRAME_TICKS, 8, video frames per animation step (≥1)
- ADDR_W, 14, ROM address width (≥ clog2(SPR_W*SPR_H*NUM_FRAMES))

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = visible region
- frame_tick  in  1  one-cycle pulse once per video frame (vertical blank)
- pos_x, pos_y  in  10 each  requested sprite top-left
- anim_en  in  1  1 = advance animation
- anim_restart  in  1  pulse: return to frame 0
- flip_h  in  1  mirror horizontally (only with SPRITE_FLIP_EN)
- bg_red, bg_green, bg_blue  in  4 each  background colour
- rom_address  out  ADDR_W  to sprite ROM, registered
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- palette_index  out  IDX_W  = rom_q, to palette
- palette_red, palette_green, palette_blue  in  4 each  palette colour
- red, green, blue  out  4 each  registered pixel colour
- sprite_hit  out  1  registered: opaque sprite pixel drawn

## Operation
- Position latch: cur_x/cur_y load pos_x/pos_y only on frame_tick, so there is no mid-frame tearing. Reset value 0.
- Animation: tick_cnt counts frame_ticks while anim_en=1. On the tick where tick_cnt==FRAME_TICKS-1, tick_cnt←0 and frame←frame+1, wrapping NUM_FRAMES-1→0. anim_en=0 holds both.
- anim_restart clears frame and tick_cnt. It wins over a simultaneous frame_tick advance; the position latch still occurs on that tick.
- Hit test uses 11-bit arithmetic (no wrap): DrawX∈[cur_x, cur_x+SPR_W), DrawY∈[cur_y, cur_y+SPR_H). A sprite partially off the right or bottom edge is simply clipped.
- Address on hit: frame·SPR_W·SPR_H + (DrawY−cur_y)·SPR_W + lx. lx = DrawX−cur_x, or SPR_W−1−(DrawX−cur_x) when flipped. On miss: 0.
- Stage 1 registers rom_address, hit_d and blank_d. Stage 2 registers the output:
  - blank_d=0 → RGB=0, sprite_hit=0
  - hit_d and rom_q≠0 → palette colour, sprite_hit=1
  - otherwise → bg colour, sprite_hit=0
- Reset values: all RGB 0, sprite_hit 0, rom_address 0, frame 0, tick_cnt 0, pipeline registers 0.

## Timing
- DrawX/DrawY/blank presented at edge n → rom_address at n+1 → RGB/sprite_hit at n+2. Fixed 2-cycle latency; the VGA controller delays sync by 2.
- frame/cur_x/cur_y update on the edge that samples frame_tick and take effect for pixels sampled on the following edge.
- Reset asserted mid-line forces outputs to 0 immediately. The first valid pixel appears 2 cycles after release.

## Configuration
- SPRITE_FLIP_EN defined: flip_h is honoured, sampled per pixel in stage 1.
- SPRITE_FLIP_EN undefined: flip_h is ignored, lx = DrawX−cur_x, and no mirror logic is synthesised.

## Test plan
- Reset: hold reset_n=0 with blank=1 → RGB=0, rom_address=0, sprite_hit=0. After release, DrawX=0,DrawY=0 with pos=(0,0) latched → rom_address=0 at n+1.
- Placement: pos=(100,200) latched, frame 0. DrawX=100,DrawY=200 → address 0. DrawX=149,DrawY=263 → address 3199. DrawX=150 → miss, bg colour at n+2.
- Transparency: hit with rom_q=0 → bg RGB. rom_q=5 → palette RGB, sprite_hit=1. blank=0 → RGB=0.
- Animation: FRAME_TICKS=8, anim_en=1. 8 ticks → frame 1, and pixel (pos) address 3200. 32 ticks → wrap to frame 0. anim_restart coincident with 8th tick → frame stays 0.
- Flip (SPRITE_FLIP_EN): pos=(0,0), flip_h=1, DrawX=0,DrawY=0 → address 49. Without the macro → address 0.
- Edge clip: pos=(620,470), DrawX=639,DrawY=479 → hit, address 9·50+19=469. Position change mid-frame is ignored until the next frame_tick.
